// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Request/response handshake bundle between a load/store
//               requester (master) and the data memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_store;
    logic [2:0]  req_load;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_store, req_load, req_addr, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_store, req_load, req_addr, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-wide data RAM behind a valid/ready request channel.
//               Sub-word stores are read-modify-write; loads are sign/zero
//               extended and returned over a valid/ready response channel.
// Config      : DMEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
//               accesses report rsp_err; otherwise they are force-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    data_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic [31:0]             r_rsp_rdata;
    logic                    r_rsp_err;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [1:0]              r_lane;
    logic [1:0]              r_size;
    logic                    r_write;
    logic                    r_unsigned;
    logic [31:0]             r_wdata;
    logic [31:0]             r_word;
    logic [31:0]             r_mem [2**ADDR_WIDTH];

    logic [1:0]  w_size;
    logic        w_unsigned;
    logic        w_rsvd;
    logic        w_err;
    logic [1:0]  w_lane;
    logic [31:0] w_rd_word;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;
    logic        w_unused;

    // Address bits above the word index only alias; they are deliberately dropped.
    assign w_unused = ^bus.req_addr[31:ADDR_WIDTH+2];

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // Decode the incoming request into access size, signedness, lane and error.
    always_comb begin
        w_size     = c_SIZE_WORD;
        w_unsigned = 1'b0;
        w_rsvd     = 1'b0;
        if (bus.req_write) begin
            case (bus.req_store)
                2'b00:   w_size = c_SIZE_WORD;
                2'b01:   w_size = c_SIZE_HALF;
                2'b10:   w_size = c_SIZE_BYTE;
                default: w_rsvd = 1'b1;
            endcase
        end else begin
            case (bus.req_load)
                3'b000:  w_size = c_SIZE_BYTE;
                3'b001:  w_size = c_SIZE_HALF;
                3'b010:  w_size = c_SIZE_WORD;
                3'b011:  begin w_size = c_SIZE_BYTE; w_unsigned = 1'b1; end
                3'b100:  begin w_size = c_SIZE_HALF; w_unsigned = 1'b1; end
                default: w_rsvd = 1'b1;
            endcase
        end
        // Lane is force-aligned; in the trapping build misaligned requests
        // never reach the RAM so the alignment there is harmless.
        case (w_size)
            c_SIZE_HALF: w_lane = {bus.req_addr[1], 1'b0};
            c_SIZE_WORD: w_lane = 2'b00;
            default:     w_lane = bus.req_addr[1:0];
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        w_err = w_rsvd
              | ((w_size == c_SIZE_HALF) & bus.req_addr[0])
              | ((w_size == c_SIZE_WORD) & (bus.req_addr[1:0] != 2'b00));
`else
        w_err = w_rsvd;
`endif
    end

    // Extract and extend the addressed lane of the word being read.
    always_comb begin
        w_rd_word = r_mem[r_idx];
        w_ld_byte = w_rd_word[{r_lane, 3'b000} +: 8];
        w_ld_half = r_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (r_size)
            c_SIZE_BYTE: w_load_data = r_unsigned ? {24'd0, w_ld_byte}
                                                  : {{24{w_ld_byte[7]}}, w_ld_byte};
            c_SIZE_HALF: w_load_data = r_unsigned ? {16'd0, w_ld_half}
                                                  : {{16{w_ld_half[15]}}, w_ld_half};
            default:     w_load_data = w_rd_word;
        endcase
    end

    // Merge the store data into the previously read word (whole word for sw).
    always_comb begin
        w_merged = r_word;
        case (r_size)
            c_SIZE_BYTE: w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
            c_SIZE_HALF: begin
                if (r_lane[1]) w_merged[31:16] = r_wdata[15:0];
                else           w_merged[15:0]  = r_wdata[15:0];
            end
            default:     w_merged = r_wdata;
        endcase
    end

    // RAM write port: the word is committed on the edge leaving WRITE.
    always_ff @(posedge clk) begin
        if (r_state == WRITE) begin
            r_mem[r_idx] <= w_merged;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_idx       <= '0;
            r_lane      <= 2'b00;
            r_size      <= c_SIZE_WORD;
            r_write     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_wdata     <= 32'd0;
            r_word      <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_idx       <= bus.req_addr[ADDR_WIDTH+1:2];
                        r_lane      <= w_lane;
                        r_size      <= w_size;
                        r_write     <= bus.req_write;
                        r_unsigned  <= w_unsigned;
                        r_wdata     <= bus.req_wdata;
                        if (w_err) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'd0;
                        end else if (bus.req_write && (w_size == c_SIZE_WORD)) begin
                            r_state <= WRITE;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                READ: begin
                    r_word <= w_rd_word;
                    if (r_write) begin
                        r_state <= WRITE;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load_data;
                        r_rsp_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_err   <= 1'b0;
                end
                default: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire
